clk_edit_sched: RTL

//  Sequences the shared keyboard editing datapath (3-key debounce + digit editor) between two targets:
//  the running time (HH:MM) and the alarm setpoint (HH:MM).
//  - Drives the editor's en/load/data_in.
//  - Validates each committed value, then routes it as a one-cycle write strobe to the owning register.
//  - Sits between the mode key filter, the time counter / alarm registers and the editor.

---
 rtl/clk_edit_sched.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/clk_edit_sched.sv
// rtl/clk_edit_sched.sv - routes the shared digit editor between time and alarm HH:MM edits
// Alarm editing (LOAD_A/EDIT_A, alarm_wr) exists only with `define CLK_EDIT_ALARM_EN.
module clk_edit_sched #(
  parameter int unsigned TIMEOUT_CYC = 500_000_000,
  parameter int unsigned HR_MAX      = 23
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_mode_flag,
  input  logic        key_any_flag,
  input  logic [15:0] time_bcd,
  input  logic [15:0] alarm_bcd,
  input  logic [15:0] kb_data_out,
  input  logic        kb_data_vld,
  output logic        kb_en,
  output logic        kb_load,
  output logic [15:0] kb_data_in,
  output logic        time_wr,
  output logic        alarm_wr,
  output logic [15:0] wr_data,
  output logic [1:0]  mode,
  output logic        err,
  output logic        timeout
);

  localparam int unsigned       CNT_W      = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0]        HR_MAX_BCD = 8'(((HR_MAX / 10) << 4) | (HR_MAX % 10));

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_T,
    S_EDIT_T
`ifdef CLK_EDIT_ALARM_EN
    ,
    S_LOAD_A,
    S_EDIT_A
`endif
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
  logic             in_edit, expire, value_ok;
  logic             load_nx, err_nx, to_nx, twr_nx, awr_nx, en_nx;
  logic [15:0]      din_nx, wdata_nx;
  logic [1:0]       mode_nx;

  // Digits are compared as BCD; hours also bounded by HR_MAX as a packed BCD byte.
  always_comb begin
    value_ok = (kb_data_out[15:12] <= 4'd2) && (kb_data_out[11:8] <= 4'd9) &&
               (kb_data_out[7:4]   <= 4'd5) && (kb_data_out[3:0]  <= 4'd9) &&
               (kb_data_out[15:8]  <= HR_MAX_BCD);
  end

  always_comb begin
    in_edit = (state == S_EDIT_T);
`ifdef CLK_EDIT_ALARM_EN
    in_edit = in_edit || (state == S_EDIT_A);
`endif
    cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    // A key press this cycle restarts the idle window, so it also vetoes expiry.
    expire  = in_edit && !key_any_flag && (cnt_inc == CNT_MAX);
  end

  always_comb begin
    state_nx = state;
    load_nx  = 1'b0;
    err_nx   = 1'b0;
    to_nx    = 1'b0;
    twr_nx   = 1'b0;
    awr_nx   = 1'b0;
    din_nx   = kb_data_in;
    wdata_nx = wr_data;
    case (state)
      S_IDLE: begin
        if (key_mode_flag) begin
          state_nx = S_LOAD_T;
          load_nx  = 1'b1;
          din_nx   = time_bcd;
        end
      end
      S_LOAD_T: state_nx = S_EDIT_T;
      S_EDIT_T: begin
        if (kb_data_vld) begin
          if (value_ok) begin
            twr_nx   = 1'b1;
            wdata_nx = kb_data_out;
            state_nx = S_IDLE;
          end else begin
            err_nx   = 1'b1;
            load_nx  = 1'b1;
            din_nx   = time_bcd;
            state_nx = S_LOAD_T;
          end
        end else if (key_mode_flag) begin
`ifdef CLK_EDIT_ALARM_EN
          load_nx  = 1'b1;
          din_nx   = alarm_bcd;
          state_nx = S_LOAD_A;
`else
          state_nx = S_IDLE;
`endif
        end else if (expire) begin
          to_nx    = 1'b1;
          state_nx = S_IDLE;
        end
      end
`ifdef CLK_EDIT_ALARM_EN
      S_LOAD_A: state_nx = S_EDIT_A;
      S_EDIT_A: begin
        if (kb_data_vld) begin
          if (value_ok) begin
            awr_nx   = 1'b1;
            wdata_nx = kb_data_out;
            state_nx = S_IDLE;
          end else begin
            err_nx   = 1'b1;
            load_nx  = 1'b1;
            din_nx   = alarm_bcd;
            state_nx = S_LOAD_A;
          end
        end else if (key_mode_flag) begin
          state_nx = S_IDLE;
        end else if (expire) begin
          to_nx    = 1'b1;
          state_nx = S_IDLE;
        end
      end
`endif
      default: state_nx = S_IDLE;
    endcase

    if (load_nx || key_any_flag) cnt_nx = '0;
    else if (in_edit)            cnt_nx = cnt_inc;
    else                         cnt_nx = cnt;

    // Outputs are registered, so they are decoded from the state being entered.
    en_nx   = (state_nx != S_IDLE);
    mode_nx = 2'd0;
    case (state_nx)
      S_LOAD_T, S_EDIT_T: mode_nx = 2'd1;
`ifdef CLK_EDIT_ALARM_EN
      S_LOAD_A, S_EDIT_A: mode_nx = 2'd2;
`endif
      default:            mode_nx = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      kb_en      <= 1'b0;
      kb_load    <= 1'b0;
      kb_data_in <= 16'd0;
      time_wr    <= 1'b0;
      alarm_wr   <= 1'b0;
      wr_data    <= 16'd0;
      mode       <= 2'd0;
      err        <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      kb_en      <= en_nx;
      kb_load    <= load_nx;
      kb_data_in <= din_nx;
      time_wr    <= twr_nx;
      alarm_wr   <= awr_nx;
      wr_data    <= wdata_nx;
      mode       <= mode_nx;
      err        <= err_nx;
      timeout    <= to_nx;
    end
  end

endmodule
